// File: rtl/adc_seq_ctrl.sv
// ADC temperature-path sequencer: starts and stops the ADC sequencer over its CSR and
// box-car averages samples into a RAM ring. Optional hysteresis alarm: define TEMP_ALARM_EN.
module adc_seq_ctrl #(
  parameter int          AVG_LOG2    = 3,
  parameter int          ADDR_W      = 4,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [11:0] ALARM_HI    = 12'hC00,
  parameter logic [11:0] ALARM_LO    = 12'hB80
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              pll_locked_i,
  output logic              csr_address_o,
  output logic              csr_write_o,
  output logic [31:0]       csr_writedata_o,
  input  logic              rsp_valid_i,
  input  logic [11:0]       rsp_data_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [11:0]       ram_data_o,
  output logic              ram_wren_o,
  output logic [11:0]       avg_data_o,
  output logic              avg_valid_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  output logic              temp_alarm_o
);

  // state     | meaning
  // IDLE      | acquisition disabled
  // WAIT_LOCK | enabled, waiting for ADC PLL lock
  // START     | one-cycle CSR write of continuous-run command
  // RUN       | collecting samples, averaging into the ring
  // STOP      | one-cycle CSR write of stop command
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  localparam int AW = 12 + AVG_LOG2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
  localparam logic [TW-1:0]       TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_bad_avg
    $error("AVG_LOG2 must be in 1..8");
  end
  if (ALARM_LO >= ALARM_HI) begin : g_bad_alarm
    $error("ALARM_LO must be below ALARM_HI");
  end

  logic [2:0]          state_q, state_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [11:0]         avg_q, avg_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;

  logic          in_run, tmo_hit, run_exit, last;
  logic [AW-1:0] acc_sum;
  logic [11:0]   avg_new;

  always_comb begin
    in_run   = (state_q == RUN);
    tmo_hit  = in_run && !rsp_valid_i && (tmo_q == '0);
    run_exit = in_run && (!enable_i || !pll_locked_i || tmo_hit);
    // An exit in the same cycle as the final sample discards that sample.
    last     = in_run && !run_exit && rsp_valid_i && (cnt_q == CNT_LAST);
    acc_sum  = acc_q + AW'(rsp_data_i);
    avg_new  = acc_sum[AW-1:AVG_LOG2];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable_i) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (!enable_i)         state_d = IDLE;
        else if (pll_locked_i) state_d = START;
      end
      START:     state_d = RUN;
      RUN:       if (run_exit) state_d = STOP;
      STOP:      state_d = enable_i ? WAIT_LOCK : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (!in_run || run_exit || last) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (rsp_valid_i) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + AVG_LOG2'(1);
    end

    tmo_d = tmo_q;
    if (state_q == START || (in_run && rsp_valid_i)) tmo_d = TMO_LOAD;
    else if (in_run && tmo_q != '0)                  tmo_d = tmo_q - TW'(1);

    wr_d  = last;
    avg_d = last ? avg_new : avg_q;
    ptr_d = wr_q ? ptr_q + ADDR_W'(1) : ptr_q;

    err_d = err_q;
    if (tmo_hit)                          err_d = 1'b1;
    else if (state_q == IDLE && !enable_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ptr_q   <= '0;
      avg_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
      avg_q   <= avg_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

`ifdef TEMP_ALARM_EN
  logic alarm_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_q <= 1'b0;
    end else if (last) begin
      if (avg_new >= ALARM_HI)      alarm_q <= 1'b1;
      else if (avg_new <= ALARM_LO) alarm_q <= 1'b0;
    end
  end
  assign temp_alarm_o = alarm_q;
`else
  assign temp_alarm_o = 1'b0;
`endif

  assign csr_address_o   = 1'b0;
  assign csr_write_o     = (state_q == START) || (state_q == STOP);
  assign csr_writedata_o = (state_q == START) ? 32'h3 : 32'h0;
  assign ram_addr_o      = ptr_q;
  assign ram_data_o      = avg_q;
  assign ram_wren_o      = wr_q;
  assign avg_data_o      = avg_q;
  assign avg_valid_o     = wr_q;
  assign busy_o          = (state_q == START) || (state_q == RUN) || (state_q == STOP);
  assign timeout_err_o   = err_q;

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
Controller for the on-chip modular ADC temperature path. Sequences the ADC sequencer CSR: start continuous conversion once the PLL is locked, stop on disable or lock loss. Collects response samples, box-car averages 2^AVG_LOG2 of them, and writes each average into the sample RAM as a ring buffer. Sits between the ADC core, the RAM and the LED/temperature display logic in the top level.

Parameters:
AVG_LOG2, 3, log2 of samples per average (1..8)
ADDR_W, 4, RAM address width; ring depth 2^ADDR_W
TIMEOUT_CYC, 4096, RUN cycles without rsp_valid before restart
ALARM_HI, 12'hC00, alarm set threshold (raw code, used only with macro)
ALARM_LO, 12'hB80, alarm clear threshold (ALARM_LO < ALARM_HI)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = acquire
pll_locked  in  1  ADC PLL lock
csr_address  out  1  sequencer CSR address, always 0
csr_write  out  1  sequencer CSR write strobe
csr_writedata  out  32  CSR data
rsp_valid  in  1  ADC response valid
rsp_data  in  12  ADC response data
ram_addr  out  ADDR_W  RAM write address
ram_data  out  12  RAM write data
ram_wren  out  1  RAM write enable, 1-cycle pulse
avg_data  out  12  latest average, held
avg_valid  out  1  1-cycle pulse with each new average
busy  out  1  high in START/RUN/STOP
timeout_err  out  1  sticky timeout flag
temp_alarm  out  1  over-threshold flag

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; accumulator, sample count, timeout counter, ram_addr cleared.
- States: IDLE, WAIT_LOCK, START, RUN, STOP.
- IDLE: enable=1 -> WAIT_LOCK; timeout_err cleared while enable=0.
- WAIT_LOCK: pll_locked=1 -> START; enable=0 -> IDLE.
- START: exactly one cycle; csr_write=1, csr_writedata=32'h3 (continuous mode, run) -> RUN.
- RUN: each rsp_valid adds rsp_data to accumulator (width 12+AVG_LOG2, no overflow possible) and increments count. On the 2^AVG_LOG2-th sample: next cycle avg_data = acc >> AVG_LOG2 (truncate), avg_valid=1, ram_wren=1, ram_data=avg_data, ram_addr = current pointer; pointer increments the cycle after the write, wrapping 2^ADDR_W-1 -> 0. Accumulator/count restart cleanly, so a rsp_valid in the write cycle counts toward the next average.
- RUN exits: enable=0 or pll_locked=0 -> STOP; timeout counter reaching TIMEOUT_CYC -> timeout_err=1, STOP. Counter clears on every rsp_valid and on RUN entry.
- STOP: one cycle; csr_write=1, csr_writedata=32'h0. Next: IDLE if enable=0; WAIT_LOCK otherwise (lock loss or timeout restart).
- Leaving RUN discards any partial accumulation; rsp_valid outside RUN ignored.
- Ring pointer and avg_data retained across enable cycles; cleared only by rst.
- csr_write is 0 in all states except START and STOP; csr_writedata is 0 when csr_write=0.
- Simultaneous enable=0 and final sample in same RUN cycle: exit wins, sample discarded, no write.

Optional Feature:
TEMP_ALARM_EN. Defined: temp_alarm updates on avg_valid cycles only; set when avg_data >= ALARM_HI, cleared when avg_data <= ALARM_LO, otherwise held (hysteresis); cleared by rst. Undefined: temp_alarm tied 0, no comparator logic.

Test Plan:
- Reset, enable=1, pll_locked=1 at cycle 5 -> one csr_write with 32'h3, then RUN; busy=1.
- AVG_LOG2=3, eight samples of 12'h100..12'h107 -> avg_data=12'h103, ram_wren at addr 0 one cycle after 8th valid.
- Feed 17 averages with ADDR_W=4 -> addresses 0..15 then 0; 17th write lands at address 0.
- No rsp_valid for 4096 RUN cycles -> timeout_err=1, csr_write 32'h0, then 32'h3 again; enable=0 clears flag.
- Drop enable after 5 samples, re-enable -> csr 32'h0 then 32'h3; first new average uses only post-restart samples.
- With TEMP_ALARM_EN: averages 12'hC10, 12'hBA0, 12'hB70 -> temp_alarm 1, 1, 0.
